// File: rtl/ex_muldiv_ctrl.sv
// Iterative 32-step multiply/divide sequencer for the EX stage.
// Owns HI/LO, runs shift-add multiply or restoring divide, and stalls the pipeline while busy.
module ex_muldiv_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            hilo_wr,
  input  logic            hilo_wr_sel,
  input  logic [XLEN-1:0] hilo_wdata,
  input  logic            hilo_rd_req,
  input  logic            hilo_rd_sel,
  output logic [XLEN-1:0] hilo_rdata,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic            stall
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   hi, lo;
  logic [XLEN-1:0]   acc;   // product high half / partial remainder
  logic [XLEN-1:0]   mq;    // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0]   opnd;  // multiplicand / divisor magnitude
  logic [CNT_W-1:0]  cnt;
  logic              neg_res, neg_rem, is_div;

  logic              idle_like, accept, b_zero, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign accept    = start && idle_like;
  assign b_zero    = (src_b == '0);
  assign a_neg     = op[0] & src_a[XLEN-1];
  assign b_neg     = op[0] & src_b[XLEN-1];
  assign mag_a     = a_neg ? (~src_a + XLEN'(1)) : src_a;
  assign mag_b     = b_neg ? (~src_b + XLEN'(1)) : src_b;

  // One shift-add multiply step: add multiplicand if LSB set, then shift {acc,mq} right.
  assign mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);

  // One restoring divide step: shift in next dividend bit, subtract divisor if it fits.
  assign div_shift = {acc, mq[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = ~div_diff[XLEN];

  assign prod      = {acc, mq};
  assign prod_fix  = neg_res ? (~prod + (2*XLEN)'(1)) : prod;
  assign quo_fix   = neg_res ? (~mq + XLEN'(1)) : mq;
  assign rem_fix   = neg_rem ? (~acc + XLEN'(1)) : acc;

  assign hilo_rdata = hilo_rd_sel ? hi : lo;
  assign stall      = busy & (start | hilo_rd_req | hilo_wr);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = op[1] ? (b_zero ? S_FIX : S_DIV) : S_MUL;
        else       state_next = S_IDLE;
      end
      S_MUL, S_DIV: if (cnt == '0) state_next = S_FIX;
      S_FIX:        state_next = S_DONE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      is_div   <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_MUL) || (state_next == S_DIV) || (state_next == S_FIX);
      done  <= (state_next == S_DONE);

      if (accept) begin
        is_div   <= op[1];
        div_zero <= op[1] & b_zero;
        cnt      <= CNT_W'(XLEN - 1);
        if (!op[1]) begin
          acc     <= '0;
          mq      <= mag_b;
          opnd    <= mag_a;
          neg_res <= a_neg ^ b_neg;
          neg_rem <= 1'b0;
        end else if (b_zero) begin
          // Divide by zero: FIX passes these through unchanged as HI=src_a, LO=all ones.
          acc     <= src_a;
          mq      <= '1;
          opnd    <= '0;
          neg_res <= 1'b0;
          neg_rem <= 1'b0;
        end else begin
          acc     <= '0;
          mq      <= mag_a;
          opnd    <= mag_b;
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
        end
      end else if (state == S_MUL) begin
        acc <= mul_sum[XLEN:1];
        mq  <= {mul_sum[0], mq[XLEN-1:1]};
        cnt <= cnt - CNT_W'(1);
      end else if (state == S_DIV) begin
        acc <= div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        mq  <= {mq[XLEN-2:0], div_ok};
        cnt <= cnt - CNT_W'(1);
      end else if (state == S_FIX) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          hi <= prod_fix[2*XLEN-1:XLEN];
          lo <= prod_fix[XLEN-1:0];
        end
      end

      // MTHI/MTLO only land when no operation is in flight and no start is issued.
      if (hilo_wr && !start && idle_like) begin
        if (hilo_wr_sel) hi <= hilo_wdata;
        else             lo <= hilo_wdata;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: cycle-accurate timing checks plus a result scoreboard.
module tb_ex_muldiv_ctrl;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hilo_wr = 1'b0;
  logic        hilo_wr_sel = 1'b0;
  logic [31:0] hilo_wdata = '0;
  logic        hilo_rd_req = 1'b0;
  logic        hilo_rd_sel = 1'b0;
  logic [31:0] hilo_rdata;
  logic        busy, done, div_zero, stall;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  ex_muldiv_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hilo_wr(hilo_wr), .hilo_wr_sel(hilo_wr_sel), .hilo_wdata(hilo_wdata),
    .hilo_rd_req(hilo_rd_req), .hilo_rd_sel(hilo_rd_sel), .hilo_rdata(hilo_rdata),
    .busy(busy), .done(done), .div_zero(div_zero), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference behaviour built from native 64-bit / integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    int          sa, sb;
    e = '0;
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else if (o == 2'b10) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'h0;
        end else begin
          sa = $signed(a); sb = $signed(b);
          e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
        end
      end
    endcase
    return e;
  endfunction

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_done: done pulse with empty scoreboard");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (dut.hi !== e.hi) begin errors++; $display("FAIL sb_hi: got %h want %h", dut.hi, e.hi); end
        checks++;
        if (dut.lo !== e.lo) begin errors++; $display("FAIL sb_lo: got %h want %h", dut.lo, e.lo); end
        checks++;
        if (div_zero !== e.dz) begin errors++; $display("FAIL sb_div_zero: got %b want %b", div_zero, e.dz); end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    cyc();
    start = 1'b1; op = o; src_a = a; src_b = b;
    sb_q.push_back(model(o, a, b));
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
    hilo_rd_sel = 1'b1; #1;
    checks++; if (hilo_rdata !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hilo_rdata); end
    hilo_rd_sel = 1'b0; #1;
    checks++; if (hilo_rdata !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", hilo_rdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu_timing();
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 34; k++) begin
      cyc();
      if (k == 1) start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== (k <= 33)) begin errors++; $display("FAIL multu_busy: cycle %0d got %b want %b", k, busy, (k <= 33)); end
      checks++;
      if (done !== (k == 34)) begin errors++; $display("FAIL multu_done: cycle %0d got %b want %b", k, done, (k == 34)); end
    end
    hilo_rd_sel = 1'b1; #1;
    checks++; if (hilo_rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hilo_rdata); end
    hilo_rd_sel = 1'b0; #1;
    checks++; if (hilo_rdata !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", hilo_rdata); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    issue(2'b01, 32'hFFFF_FFFD, 32'd5);
    for (int k = 1; k <= 34; k++) begin
      cyc();
      if (k == 1) begin op = 2'b01; src_a = 32'd7; src_b = 32'hFFFF_FFFF; end
      if (k == 34) sb_q.push_back(model(2'b01, 32'd7, 32'hFFFF_FFFF));
      @(negedge clk);
      checks++;
      if (stall !== (k <= 33)) begin errors++; $display("FAIL b2b_stall: cycle %0d got %b want %b", k, stall, (k <= 33)); end
    end
    cyc(); start = 1'b0;
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got no done want done within 40 cycles"); end
    checks++; if (dut.lo !== 32'hFFFF_FFF9) begin errors++; $display("FAIL b2b_lo: got %h want fffffff9", dut.lo); end
  endtask

  task automatic test_div_signed();
    bit ok;
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    cyc(); start = 1'b0;
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL div_timeout: got no done want done"); end
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    cyc(); start = 1'b0;
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL div_ovf_timeout: got no done want done"); end
    checks++; if (dut.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", dut.lo); end
    issue(2'b10, 32'hDEAD_BEEF, 32'h0000_1234);
    cyc(); start = 1'b0;
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL divu_timeout: got no done want done"); end
  endtask

  task automatic test_div_zero();
    bit ok;
    issue(2'b10, 32'd100, 32'd0);
    for (int k = 1; k <= 2; k++) begin
      cyc();
      if (k == 1) start = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== (k == 2)) begin errors++; $display("FAIL dz_done: cycle %0d got %b want %b", k, done, (k == 2)); end
      checks++;
      if (busy !== (k == 1)) begin errors++; $display("FAIL dz_busy: cycle %0d got %b want %b", k, busy, (k == 1)); end
    end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    issue(2'b10, 32'd9, 32'd4);
    cyc(); start = 1'b0;
    @(negedge clk);
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b want 0", div_zero); end
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dz_next_timeout: got no done want done"); end
  endtask

  task automatic test_mflo_stall();
    issue(2'b00, 32'd6, 32'd7);
    for (int k = 1; k <= 34; k++) begin
      cyc();
      if (k == 1) begin start = 1'b0; hilo_rd_req = 1'b1; hilo_rd_sel = 1'b0; end
      @(negedge clk);
      checks++;
      if (stall !== (k <= 33)) begin errors++; $display("FAIL mflo_stall: cycle %0d got %b want %b", k, stall, (k <= 33)); end
    end
    checks++; if (hilo_rdata !== 32'd42) begin errors++; $display("FAIL mflo_data: got %h want 0000002a", hilo_rdata); end
    cyc(); hilo_rd_req = 1'b0;
    hilo_wr = 1'b1; hilo_wr_sel = 1'b1; hilo_wdata = 32'h0000_1234;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b want 0", stall); end
    cyc(); hilo_wr = 1'b0; hilo_rd_sel = 1'b1; #1;
    checks++; if (hilo_rdata !== 32'h0000_1234) begin errors++; $display("FAIL mthi_data: got %h want 00001234", hilo_rdata); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    cyc();
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd7;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 1) start = 1'b0;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
    cyc();
    start = 1'b1; hilo_rd_req = 1'b1; rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %b want 0", stall); end
    hilo_rd_sel = 1'b1; #1;
    checks++; if (hilo_rdata !== 32'h0) begin errors++; $display("FAIL rmid_hi: got %h want 0", hilo_rdata); end
    hilo_rd_sel = 1'b0; #1;
    checks++; if (hilo_rdata !== 32'h0) begin errors++; $display("FAIL rmid_lo: got %h want 0", hilo_rdata); end
    start = 1'b0; hilo_rd_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    issue(2'b10, 32'd1000, 32'd7);
    cyc(); start = 1'b0;
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_after_timeout: got no done want done"); end
    checks++; if (dut.lo !== 32'd142) begin errors++; $display("FAIL rmid_after_lo: got %h want 0000008e", dut.lo); end
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_back_to_back();
    test_div_signed();
    test_div_zero();
    test_mflo_stall();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
